multicycle_control: RTL and testbench
=====================================

# multicycle_control

Finite-state control unit for the multicycle RV64 datapath. It receives the 7-bit `opcode` from the datapath's instruction register and drives every datapath control input, one instruction step per clock:

- `ALUOp`, `ALUSrcA`, `ALUSrcB`, `PCSource`
- `MemRead`, `MemWrite`, `IorD`, `MemtoReg`
- `RegWrite`, `IRWrite`, `PCWrite`, `PCWriteCond`

It is the other end of the datapath's control interface. It also reports its current state, a sticky illegal-opcode flag and a retired-instruction counter.

## Interface
Parameters:
- `LD`, 7'b000_0011, load-doubleword opcode
- `SD`, 7'b010_0011, store-doubleword opcode
- `RTYPE`, 7'b011_0011, R-format ALU opcode
- `BEQ`, 7'b110_0011, branch-equal opcode
- `CNTW`, 32, width of `instr_count`

Ports (clock and reset first):
- `clock` in 1: single clock; all state changes on its rising edge. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: `IR[6:0]` from the datapath. Valid from DECODE onward.
- `ALUOp` out 2: 00 = add, 01 = subtract, 10 = funct-decoded.
- `ALUSrcB` out 2: 00 = B, 01 = constant 4, 10 = ImmGen, 11 = PCOffset.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `PCSource` out 1: 0 = ALU result, 1 = ALUOut.
- `IorD` out 1: 0 = PC address, 1 = ALUOut address.
- `MemtoReg` out 1: 0 = ALUOut, 1 = MDR.
- `MemRead`, `MemWrite`, `RegWrite`, `IRWrite`, `PCWrite`, `PCWriteCond` out 1 each: strobes.
- `state` out 4: current state encoding.
- `illegal` out 1: sticky unsupported-opcode flag.
- `instr_count` out CNTW: number of retired instructions.

## Operation
Moore FSM: every output is a function of `state` only. Any output not listed for a state is 0.

States and their outputs:
- 0 FETCH: `MemRead`, `IRWrite`, `PCWrite`; `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `IorD`=0, `PCSource`=0. Goes to DECODE.
- 1 DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00; the branch target goes into ALUOut. Next state by `opcode`:
  - LD or SD → MEMADR
  - RTYPE → EXEC
  - BEQ → BRANCH
  - anything else → ILLEGAL
- 2 MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. LD → MEMRD; SD → MEMWR.
- 3 MEMRD: `MemRead`, `IorD`=1. Goes to MEMWB.
- 4 MEMWB: `RegWrite`, `MemtoReg`=1. Goes to FETCH.
- 5 MEMWR: `MemWrite`, `IorD`=1. Goes to FETCH.
- 6 EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Goes to RWB.
- 7 RWB: `RegWrite`, `MemtoReg`=0. Goes to FETCH.
- 8 BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`, `PCSource`=1. Goes to FETCH.
- 9 ILLEGAL: all strobes 0; `illegal`=1. Stays here until `reset`.

Encodings 10–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.

`instr_count` rules:
- Increments by 1 on each clock edge where `state` is MEMWB, MEMWR, RWB or BRANCH (retire edge).
- Wraps modulo 2^CNTW.

`illegal` is set on the DECODE→ILLEGAL edge and cleared only by `reset`.

`opcode` is sampled only in DECODE and MEMADR. The IR is stable in those states because `IRWrite` is asserted only in FETCH.

## Timing
- Reset values (edge with `reset`=1): `state`=FETCH, `illegal`=0, `instr_count`=0.
- While `reset` is high, all strobes are forced to 0: `MemRead`, `MemWrite`, `RegWrite`, `IRWrite`, `PCWrite`, `PCWriteCond`. Mux selects are 0.
- The first FETCH strobes appear in the first cycle after `reset` falls.
- Cycles per instruction, FETCH inclusive: LD 5, SD 4, RTYPE 4, BEQ 3.
- Reset mid-instruction: `reset` overrides all transitions on the same edge. Pending strobes are dropped, with no partial memory or register write. `instr_count` does not increment on that edge even if the state was a retire state.
- Output decode is combinational from the `state` register. There is no output register stage.

## Test plan
- **Reset.** Hold `reset` 2 cycles with `opcode`=X, then release.
  - During reset: all strobes 0, `state`=0, `instr_count`=0, `illegal`=0.
  - Next cycle: `MemRead`=`IRWrite`=`PCWrite`=1, `ALUSrcB`=01.
- **LD.** `opcode`=0000011 → state sequence 0,1,2,3,4,0.
  - `MemRead`=1 with `IorD`=1 in state 3.
  - `RegWrite`=1 with `MemtoReg`=1 in state 4.
  - `instr_count` goes 0→1.
- **SD then RTYPE back-to-back.**
  - SD gives states 0,1,2,5 with `MemWrite`=1 only in state 5.
  - RTYPE (0110011) gives states 0,1,6,7 with `ALUOp`=10 in state 6.
  - `instr_count`=2 after 8 cycles.
- **BEQ.** `opcode`=1100011 → states 0,1,8,0.
  - In state 8: `PCWriteCond`=1, `PCSource`=1, `ALUOp`=01, `PCWrite`=0.
  - Three BEQs give `instr_count`=3 in 9 cycles.
- **Illegal.** `opcode`=0010011 → DECODE then ILLEGAL.
  - `illegal`=1 and no strobes for 20 cycles; `instr_count` unchanged.
  - `reset` clears `illegal` and returns to FETCH.
- **Reset mid-operation.** Assert `reset` on the cycle in MEMWR (state 5) with `instr_count`=4.
  - Next cycle: `state`=0, `MemWrite`=0, `instr_count`=0.
- **Wrap.** Run 5 BEQs with CNTW=2 → `instr_count` reads 1 at the end.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV64 control unit: Moore FSM that sequences one instruction
// step per clock and drives every datapath control input from the current
// state. Also keeps a sticky illegal-opcode flag and a retired-instruction
// counter.
module multicycle_control #(
    parameter logic [6:0] LD    = 7'b000_0011,
    parameter logic [6:0] SD    = 7'b010_0011,
    parameter logic [6:0] RTYPE = 7'b011_0011,
    parameter logic [6:0] BEQ   = 7'b110_0011,
    parameter int         CNTW  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [6:0]      opcode,
    output logic [1:0]      ALUOp,
    output logic [1:0]      ALUSrcB,
    output logic            ALUSrcA,
    output logic            PCSource,
    output logic            IorD,
    output logic            MemtoReg,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic [3:0]      state,
    output logic            illegal,
    output logic [CNTW-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_ILLEGAL = 4'd9
    } state_t;

    state_t          state_q, state_d;
    logic            illegal_q, illegal_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            retire;

    // The last step of every legal instruction retires it.
    assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                    (state_q == S_RWB)   || (state_q == S_BRANCH);

    // State, sticky flag and counter registers; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Next-state logic; opcode is only looked at in DECODE and MEMADR,
    // where the instruction register is guaranteed stable.
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        count_d   = count_q + CNTW'(retire);
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == LD || opcode == SD) begin
                    state_d = S_MEMADR;
                end else if (opcode == RTYPE) begin
                    state_d = S_EXEC;
                end else if (opcode == BEQ) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d   = S_ILLEGAL;
                    illegal_d = 1'b1;
                end
            end
            // Only LD and SD reach MEMADR, so anything not SD is the load.
            S_MEMADR:  state_d = (opcode == SD) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_EXEC:    state_d = S_RWB;
            S_RWB:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            // Unreachable encodings recover to FETCH.
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode from the state register; everything is held at
    // zero while reset is asserted so no partial write can escape.
    always_comb begin
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        ALUSrcA     = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        MemtoReg    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'b01;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a directed vector table followed by random
// instruction streams checked against a per-instruction step model.
module tb_multicycle_control;

  localparam logic [6:0] OP_LD    = 7'b000_0011;
  localparam logic [6:0] OP_SD    = 7'b010_0011;
  localparam logic [6:0] OP_RTYPE = 7'b011_0011;
  localparam logic [6:0] OP_BEQ   = 7'b110_0011;
  localparam logic [6:0] OP_ILL   = 7'b001_0011;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       pc_source;
    logic       iord;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [3:0]  st;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [1:0]  alu_op, alu_src_b, w_alu_op, w_alu_src_b;
  logic        alu_src_a, pc_source, iord, mem_to_reg;
  logic        mem_read, mem_write, reg_write, ir_write, pc_write, pc_write_cond;
  logic        w_alu_src_a, w_pc_source, w_iord, w_mem_to_reg;
  logic        w_mem_read, w_mem_write, w_reg_write, w_ir_write, w_pc_write, w_pc_write_cond;
  logic [3:0]  state, w_state;
  logic        illegal, w_illegal;
  logic [31:0] instr_count;
  logic [1:0]  w_instr_count;

  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs[$];
  logic [3:0] exp_q[$];

  // clock/reset block
  always #5 clock = ~clock;

  multicycle_control u_dut (
    .clock(clock), .reset(reset), .opcode(opcode),
    .ALUOp(alu_op), .ALUSrcB(alu_src_b), .ALUSrcA(alu_src_a),
    .PCSource(pc_source), .IorD(iord), .MemtoReg(mem_to_reg),
    .MemRead(mem_read), .MemWrite(mem_write), .RegWrite(reg_write),
    .IRWrite(ir_write), .PCWrite(pc_write), .PCWriteCond(pc_write_cond),
    .state(state), .illegal(illegal), .instr_count(instr_count)
  );

  multicycle_control #(.CNTW(2)) u_wrap (
    .clock(clock), .reset(reset), .opcode(opcode),
    .ALUOp(w_alu_op), .ALUSrcB(w_alu_src_b), .ALUSrcA(w_alu_src_a),
    .PCSource(w_pc_source), .IorD(w_iord), .MemtoReg(w_mem_to_reg),
    .MemRead(w_mem_read), .MemWrite(w_mem_write), .RegWrite(w_reg_write),
    .IRWrite(w_ir_write), .PCWrite(w_pc_write), .PCWriteCond(w_pc_write_cond),
    .state(w_state), .illegal(w_illegal), .instr_count(w_instr_count)
  );

  // Control settings of each step, straight from the state table.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st);
    ctrl_t c;
    c = '0;
    case (st)
      4'd0: begin c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01; end
      4'd1: c.alu_src_b = 2'b11;
      4'd2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd3: begin c.mem_read = 1; c.iord = 1; end
      4'd4: begin c.reg_write = 1; c.mem_to_reg = 1; end
      4'd5: begin c.mem_write = 1; c.iord = 1; end
      4'd6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      4'd7: c.reg_write = 1;
      4'd8: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Drive one cycle's inputs, check outputs, advance to the next cycle.
  task automatic drive_check(input logic r, input logic [6:0] op, input logic [3:0] st,
                             input logic ill, input logic [31:0] cnt);
    ctrl_t act, w_act, exp;
    reset  = r;
    opcode = op;
    #1;
    act = {alu_op, alu_src_b, alu_src_a, pc_source, iord, mem_to_reg,
           mem_read, mem_write, reg_write, ir_write, pc_write, pc_write_cond};
    w_act = {w_alu_op, w_alu_src_b, w_alu_src_a, w_pc_source, w_iord, w_mem_to_reg,
             w_mem_read, w_mem_write, w_reg_write, w_ir_write, w_pc_write, w_pc_write_cond};
    exp = r ? ctrl_t'(0) : exp_ctrl(st);
    chk("state", 32'(state), 32'(st));
    chk("ctrl", 32'(act), 32'(exp));
    chk("illegal", 32'(illegal), 32'(ill));
    chk("instr_count", instr_count, cnt);
    chk("wrap_ctrl", 32'(w_act), 32'(exp));
    chk("wrap_count", 32'(w_instr_count), 32'(cnt[1:0]));
    @(negedge clock);
  endtask

  task automatic add(input logic r, input logic [6:0] op, input logic [3:0] st,
                     input logic ill, input logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.op = op; v.st = st; v.ill = ill; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [6:0]  op, rop;
    logic [31:0] cnt;
    logic        r, is_ill, aborted;
    logic [3:0]  st;
    int          k;

    // directed table: reset, LD, SD, RTYPE, 3xBEQ, reset in MEMWR,
    // illegal hold, reset out of ILLEGAL, 5xBEQ wrap on the 2-bit counter
    add(1, 7'b0, 0, 0, 0);
    add(0, OP_LD, 0, 0, 0); add(0, OP_LD, 1, 0, 0); add(0, OP_LD, 2, 0, 0);
    add(0, OP_LD, 3, 0, 0); add(0, OP_LD, 4, 0, 0);
    add(0, OP_SD, 0, 0, 1); add(0, OP_SD, 1, 0, 1); add(0, OP_SD, 2, 0, 1);
    add(0, OP_SD, 5, 0, 1);
    add(0, OP_RTYPE, 0, 0, 2); add(0, OP_RTYPE, 1, 0, 2);
    add(0, OP_RTYPE, 6, 0, 2); add(0, OP_RTYPE, 7, 0, 2);
    for (int b = 0; b < 3; b++) begin
      add(0, OP_BEQ, 0, 0, 32'(3 + b)); add(0, OP_BEQ, 1, 0, 32'(3 + b));
      add(0, OP_BEQ, 8, 0, 32'(3 + b));
    end
    add(0, OP_SD, 0, 0, 6); add(0, OP_SD, 1, 0, 6); add(0, OP_SD, 2, 0, 6);
    add(1, OP_SD, 5, 0, 6);
    add(0, OP_ILL, 0, 0, 0); add(0, OP_ILL, 1, 0, 0);
    for (int i = 0; i < 20; i++) add(0, OP_ILL, 9, 1, 0);
    add(1, OP_ILL, 9, 1, 0);
    for (int b = 0; b < 5; b++) begin
      add(0, OP_BEQ, 0, 0, 32'(b)); add(0, OP_BEQ, 1, 0, 32'(b));
      add(0, OP_BEQ, 8, 0, 32'(b));
    end
    add(0, OP_BEQ, 0, 0, 5);

    reset  = 1'b1;
    opcode = 7'b0;
    @(posedge clock);
    @(negedge clock);
    foreach (vecs[i]) drive_check(vecs[i].rst, vecs[i].op, vecs[i].st, vecs[i].ill, vecs[i].cnt);

    // random instruction stream against the step model
    reset = 1'b1;
    @(negedge clock);
    cnt = 0;
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 9);
      if (k < 3)      op = OP_LD;
      else if (k < 5) op = OP_SD;
      else if (k < 7) op = OP_RTYPE;
      else if (k < 9) op = OP_BEQ;
      else begin
        op = 7'($urandom_range(0, 127));
        while (op == OP_LD || op == OP_SD || op == OP_RTYPE || op == OP_BEQ)
          op = 7'($urandom_range(0, 127));
      end
      exp_q.delete();
      exp_q.push_back(4'd0);
      exp_q.push_back(4'd1);
      case (op)
        OP_LD:    begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
        OP_SD:    begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
        OP_RTYPE: begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
        OP_BEQ:   exp_q.push_back(4'd8);
        default:  ;
      endcase
      is_ill  = (exp_q.size() == 2);
      aborted = 1'b0;
      while (exp_q.size() > 0) begin
        st  = exp_q.pop_front();
        r   = ($urandom_range(0, 39) == 0);
        rop = (st == 4'd0) ? 7'($urandom_range(0, 127)) : op;
        drive_check(r, rop, st, 1'b0, cnt);
        if (r) begin
          cnt = 0;
          exp_q.delete();
          aborted = 1'b1;
        end else if (exp_q.size() == 0 && !is_ill) begin
          cnt = cnt + 1;
        end
      end
      if (is_ill && !aborted) begin
        repeat ($urandom_range(1, 4)) drive_check(1'b0, op, 4'd9, 1'b1, cnt);
        drive_check(1'b1, op, 4'd9, 1'b1, cnt);
        cnt = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
